// File: rtl/morse_keyer_decoder.sv
// rtl/morse_keyer_decoder.sv - Morse key timer/classifier feeding a registered ASCII lookup ROM
// Classifies presses as dot/dash, packs letters as {len,sym}, and issues letter/space lookups.
module morse_keyer_decoder #(
  parameter int TICKS_PER_UNIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_in,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic       overflow
);

  localparam int TW = (TICKS_PER_UNIT > 2) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;

  state_t        state;
  logic          sync1, ks;
  logic [TW-1:0] tick;
  logic [3:0]    units;
  logic [4:0]    sym;
  logic [2:0]    len;
  logic          letter_ovf;
  logic          p1, p2;

  logic          wrap;
  logic [3:0]    units_inc;
  logic [TW-1:0] tick_next;

  // Synchronizer is deliberately not reset so a key held through reset is seen on the first cycle after release.
  always_ff @(posedge clk) begin
    sync1 <= key_in;
    ks    <= sync1;
  end

  // units_inc counts the current cycle too, so a press of N cycles is a dash exactly when N >= 2*TICKS_PER_UNIT.
  always_comb begin
    wrap      = (tick == TICK_MAX);
    units_inc = (wrap && units != 4'd15) ? units + 4'd1 : units;
    tick_next = wrap ? '0 : tick + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tick        <= '0;
      units       <= 4'd0;
      sym         <= 5'd0;
      len         <= 3'd0;
      letter_ovf  <= 1'b0;
      p1          <= 1'b0;
      p2          <= 1'b0;
      rom_addr    <= 8'h00;
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      p2          <= p1;
      p1          <= 1'b0;
      ascii_valid <= p2;
      if (p2) ascii_out <= rom_data;

      tick  <= tick_next;
      units <= units_inc;

      case (state)
        IDLE: begin
          tick  <= '0;
          units <= 4'd0;
          if (ks) state <= MARK;
        end
        MARK: begin
          if (!ks) begin
            if (len < 3'd5) begin
              sym <= {sym[3:0], (units_inc >= 4'd2)};
              len <= len + 3'd1;
            end else begin
              letter_ovf <= 1'b1;
            end
            state <= GAP;
            tick  <= '0;
            units <= 4'd0;
          end
        end
        GAP: begin
          if (ks) begin
            state <= MARK;
            tick  <= '0;
            units <= 4'd0;
          end else if (units_inc == 4'd3) begin
            rom_addr   <= letter_ovf ? 8'hE0 : {len, sym};
            if (letter_ovf) overflow <= 1'b1;
            p1         <= 1'b1;
            sym        <= 5'd0;
            len        <= 3'd0;
            letter_ovf <= 1'b0;
            state      <= WORD;
            tick       <= '0;
            units      <= 4'd0;
          end
        end
        WORD: begin
          if (ks) begin
            state <= MARK;
            tick  <= '0;
            units <= 4'd0;
          end else if (units_inc == 4'd7) begin
            rom_addr <= 8'h00;
            p1       <= 1'b1;
            state    <= IDLE;
            tick     <= '0;
            units    <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
